// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the adder-tree operand loader.
// Holds default widths, the lane-index type and the bank fill state.
package adder_tree_pkg;

  localparam int DEFAULT_ADDER_WIDTH = 23;
  localparam int DEFAULT_NUM_LANES   = 8;

  typedef logic [$clog2(DEFAULT_NUM_LANES)-1:0] lane_idx_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } bank_state_t;

  // A group of NUM_LANES operands needs one more bit than a lane index.
  function automatic int count_bits(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/adder_tree_loader_bank.sv
// One operand bank: lane registers, write count and closed (FULL) flag.
// Fills lane by lane, closes on last lane or wr_last, clears itself on retire.
module adder_tree_loader_bank
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
  parameter int NUM_LANES   = DEFAULT_NUM_LANES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [ADDER_WIDTH-1:0]           wr_data,
  input  logic                             wr_last,
  input  logic                             retire,
  output logic [NUM_LANES*ADDER_WIDTH-1:0] data,
  output logic [$clog2(NUM_LANES):0]       count,
  output logic                             closed
);

  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int COUNT_W = count_bits(NUM_LANES);
  localparam logic [COUNT_W-1:0] LAST_LANE = COUNT_W'(NUM_LANES - 1);

  bank_state_t                           state_q;
  bank_state_t                           state_d;
  logic [NUM_LANES-1:0][ADDER_WIDTH-1:0] lane_q;
  logic [COUNT_W-1:0]                    count_q;
  logic                                  write;
  logic                                  clear;

  always_comb begin
    state_d = state_q;
    write   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      FILL: begin
        if (wr_en) begin
          write = 1'b1;
          if (wr_last || (count_q == LAST_LANE)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (retire) begin
          clear   = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Unwritten lanes stay zero because a retired bank is wiped before refilling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      if (write) begin
        lane_q[count_q[LANE_W-1:0]] <= wr_data;
        count_q                     <= count_q + COUNT_W'(1);
      end else if (clear) begin
        lane_q  <= '0;
        count_q <= '0;
      end
    end
  end

  assign data   = lane_q;
  assign count  = count_q;
  assign closed = (state_q == FULL);

endmodule

// File: rtl/adder_tree_operand_loader.sv
// Packs a stream of operands into lane groups for a parallel adder tree.
// Define ADDER_TREE_LOADER_PINGPONG_EN for two alternating banks; default is one bank.
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
  parameter int NUM_LANES   = DEFAULT_NUM_LANES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ADDER_WIDTH-1:0]           in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANES*ADDER_WIDTH-1:0] out_data,
  output logic [$clog2(NUM_LANES):0]       out_count
);

  localparam int BUS_W   = NUM_LANES * ADDER_WIDTH;
  localparam int COUNT_W = count_bits(NUM_LANES);

  logic               accept;
  logic               take;
  logic [BUS_W-1:0]   sel_data;
  logic [COUNT_W-1:0] sel_count;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

`ifdef ADDER_TREE_LOADER_PINGPONG_EN

  localparam logic [COUNT_W-1:0] LAST_LANE = COUNT_W'(NUM_LANES - 1);

  logic [BUS_W-1:0]   bank_data  [2];
  logic [COUNT_W-1:0] bank_count [2];
  logic [1:0]         bank_closed;
  logic               wr_sel;
  logic               rd_sel;
  logic               closing;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    adder_tree_loader_bank #(
      .ADDER_WIDTH (ADDER_WIDTH),
      .NUM_LANES   (NUM_LANES)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept && (int'(wr_sel) == g)),
      .wr_data (in_data),
      .wr_last (in_last),
      .retire  (take && (int'(rd_sel) == g)),
      .data    (bank_data[g]),
      .count   (bank_count[g]),
      .closed  (bank_closed[g])
    );
  end

  assign closing = accept && (in_last || (bank_count[wr_sel] == LAST_LANE));

  // The write bank can only be closed when both banks hold finished groups.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (closing) begin
        wr_sel <= ~wr_sel;
      end
      if (take) begin
        rd_sel <= ~rd_sel;
      end
    end
  end

  assign in_ready  = !reset && !bank_closed[wr_sel];
  assign out_valid = !reset && bank_closed[rd_sel];
  assign sel_data  = bank_data[rd_sel];
  assign sel_count = bank_count[rd_sel];

`else

  logic [BUS_W-1:0]   bank_data;
  logic [COUNT_W-1:0] bank_count;
  logic               bank_closed;

  adder_tree_loader_bank #(
    .ADDER_WIDTH (ADDER_WIDTH),
    .NUM_LANES   (NUM_LANES)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (in_data),
    .wr_last (in_last),
    .retire  (take),
    .data    (bank_data),
    .count   (bank_count),
    .closed  (bank_closed)
  );

  assign in_ready  = !reset && !bank_closed;
  assign out_valid = !reset && bank_closed;
  assign sel_data  = bank_data;
  assign sel_count = bank_count;

`endif

  // Outputs read as zero whenever no closed group is presented.
  assign out_data  = out_valid ? sel_data  : '0;
  assign out_count = out_valid ? sel_count : '0;

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Directed, table-driven bench for adder_tree_operand_loader (8 lanes x 23 bits).
// Expectations follow ADDER_TREE_LOADER_PINGPONG_EN the same way the design does.
module tb_adder_tree_operand_loader;

  localparam int W     = 23;
  localparam int N     = 8;
  localparam int BUS_W = W * N;
  localparam int CW    = $clog2(N) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic [CW-1:0]    out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_tree_operand_loader #(
    .ADDER_WIDTH (W),
    .NUM_LANES   (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  typedef logic [W-1:0] lane_arr_t [N];

  typedef struct {
    string     name;
    int        nbeats;
    logic      use_last;
    lane_arr_t beat;
    lane_arr_t lane;
    int        count;
  } vec_t;

  vec_t vecs [6];

  function automatic lane_arr_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    lane_arr_t r;
    r[0] = W'(a0); r[1] = W'(a1); r[2] = W'(a2); r[3] = W'(a3);
    r[4] = W'(a4); r[5] = W'(a5); r[6] = W'(a6); r[7] = W'(a7);
    return r;
  endfunction

  function automatic logic [BUS_W-1:0] pack(input lane_arr_t l);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = l[k];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_count(input string name, input logic [CW-1:0] act, input int exp);
    checks++;
    if (act !== CW'(exp)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents one beat and returns at the falling edge after it was accepted.
  task automatic apply_stimulus(input logic [W-1:0] d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout: got 0 expected 1 within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_vector(input vec_t v);
    for (int j = 0; j < v.nbeats; j++) begin
      apply_stimulus(v.beat[j], v.use_last && (j == v.nbeats - 1));
    end
    go_idle();
    check_flag({v.name, "_valid"}, out_valid, 1'b1);
    check_output({v.name, "_data"}, out_data, pack(v.lane));
    check_count({v.name, "_count"}, out_count, v.count);
    @(negedge clk);
    check_flag({v.name, "_retired"}, out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lane_arr_t grp_a;
    lane_arr_t grp_b;
    vec_t      rv;
    int        groups_seen;
    int        ready_drops;

    vecs[0].name = "full8";  vecs[0].nbeats = 8; vecs[0].use_last = 1'b1; vecs[0].count = 8;
    vecs[0].beat = mk(1, 2, 3, 4, 5, 6, 7, 8);
    vecs[0].lane = mk(1, 2, 3, 4, 5, 6, 7, 8);
    vecs[1].name = "three";  vecs[1].nbeats = 3; vecs[1].use_last = 1'b1; vecs[1].count = 3;
    vecs[1].beat = mk(5, 6, 7, 0, 0, 0, 0, 0);
    vecs[1].lane = mk(5, 6, 7, 0, 0, 0, 0, 0);
    vecs[2].name = "single"; vecs[2].nbeats = 1; vecs[2].use_last = 1'b1; vecs[2].count = 1;
    vecs[2].beat = mk('h42, 0, 0, 0, 0, 0, 0, 0);
    vecs[2].lane = mk('h42, 0, 0, 0, 0, 0, 0, 0);
    vecs[3].name = "nolast"; vecs[3].nbeats = 8; vecs[3].use_last = 1'b0; vecs[3].count = 8;
    vecs[3].beat = mk('h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17);
    vecs[3].lane = mk('h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17);
    vecs[4].name = "maxval"; vecs[4].nbeats = 8; vecs[4].use_last = 1'b1; vecs[4].count = 8;
    vecs[4].beat = mk('h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF);
    vecs[4].lane = mk('h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF);
    vecs[5].name = "alt2";   vecs[5].nbeats = 2; vecs[5].use_last = 1'b1; vecs[5].count = 2;
    vecs[5].beat = mk('h2AAAAA, 'h555555, 0, 0, 0, 0, 0, 0);
    vecs[5].lane = mk('h2AAAAA, 'h555555, 0, 0, 0, 0, 0, 0);

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_flag("reset_in_ready", in_ready, 1'b0);
    check_flag("reset_out_valid", out_valid, 1'b0);
    check_output("reset_out_data", out_data, '0);
    check_count("reset_out_count", out_count, 0);
    reset = 1'b0;
    #1;
    check_flag("post_reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i]);
    end

    // Backpressure: a closed group must stay frozen while out_ready is low.
    grp_a = mk('h100, 'h101, 'h102, 'h103, 0, 0, 0, 0);
    grp_b = mk('h200, 'h201, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    apply_stimulus(W'('h100), 1'b0);
    apply_stimulus(W'('h101), 1'b0);
    apply_stimulus(W'('h102), 1'b0);
    apply_stimulus(W'('h103), 1'b1);
    go_idle();
    check_flag("hold_valid", out_valid, 1'b1);
`ifdef ADDER_TREE_LOADER_PINGPONG_EN
    check_output("hold_first_data", out_data, pack(grp_a));
    apply_stimulus(W'('h200), 1'b0);
    apply_stimulus(W'('h201), 1'b1);
    go_idle();
    for (int c = 0; c < 8; c++) begin
      check_output("hold_pp_data", out_data, pack(grp_a));
      check_count("hold_pp_count", out_count, 4);
      check_flag("hold_pp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_flag("hold_pp_second_valid", out_valid, 1'b1);
    check_output("hold_pp_second_data", out_data, pack(grp_b));
    check_count("hold_pp_second_count", out_count, 2);
    @(negedge clk);
    check_flag("hold_pp_drained", out_valid, 1'b0);
`else
    for (int c = 0; c < 10; c++) begin
      check_output("hold_data", out_data, pack(grp_a));
      check_count("hold_count", out_count, 4);
      check_flag("hold_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_flag("hold_retired_valid", out_valid, 1'b0);
    check_flag("hold_retired_in_ready", in_ready, 1'b1);
`endif

`ifdef ADDER_TREE_LOADER_PINGPONG_EN
    // Streaming: 32 back-to-back beats must drain as four in-order groups.
    groups_seen = 0;
    ready_drops = 0;
    for (int i = 0; i < 32 + 3; i++) begin
      if (i < 32) begin
        if (!in_ready) ready_drops++;
        in_valid = 1'b1;
        in_data  = W'('h300 + i);
        in_last  = 1'b0;
      end else begin
        go_idle();
      end
      @(negedge clk);
      if (out_valid) begin
        if (groups_seen < 4) begin
          lane_arr_t g;
          for (int k = 0; k < N; k++) g[k] = W'('h300 + 8 * groups_seen + k);
          check_output("stream_group_data", out_data, pack(g));
        end else begin
          check_flag("stream_extra_group", out_valid, 1'b0);
        end
        groups_seen++;
      end
    end
    go_idle();
    check_output("stream_ready_drops", BUS_W'(ready_drops), '0);
    check_output("stream_groups", BUS_W'(groups_seen), BUS_W'(4));
`endif

    // Reset in the middle of a group discards the partial operands.
    apply_stimulus(W'('hA1), 1'b0);
    apply_stimulus(W'('hA2), 1'b0);
    apply_stimulus(W'('hA3), 1'b0);
    apply_stimulus(W'('hA4), 1'b0);
    go_idle();
    check_flag("partial_not_valid", out_valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_flag("midreset_in_ready", in_ready, 1'b0);
    check_output("midreset_out_data", out_data, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_flag("midreset_release_valid", out_valid, 1'b0);
    check_flag("midreset_release_ready", in_ready, 1'b1);
    rv.name     = "after_reset";
    rv.nbeats   = 8;
    rv.use_last = 1'b1;
    rv.count    = 8;
    rv.beat     = mk(9, 10, 11, 12, 13, 14, 15, 16);
    rv.lane     = mk(9, 10, 11, 12, 13, 14, 15, 16);
    run_vector(rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
